ram_sequential_writer: RTL and testbench

Loads a contiguous region of the single-ported inferred RAM (`ram_single_ported_inferred`) by driving its write port. It is the write side of the RAM interface, complementing the sequential address-sweep reader. Two modes: stream mode accepts words over a valid/ready handshake, and fill mode writes a constant value. It sits between a data source (UART/stream front end or the control FSM) and the RAM instance used by the count-unique-values design.

---
 rtl/ram_sequential_writer.sv | 166 ++++++++++++++++
 tb/tb_ram_sequential_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sequential_writer.sv
// ram_sequential_writer: loads a contiguous RAM region, streamed (valid/ready) or constant fill.
// Ports: clk, reset_n (sync, active-low); start/mode/base/count/fill sampled in IDLE;
//   s_valid_in/s_data_in/s_ready_out stream side; ram_* write port; busy/done/words_written status.
module ram_sequential_writer #(
  parameter int NUM_WORD_BITS = 32,
  parameter int NUM_WORDS     = 1024,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int CW = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_in,
  input  logic                     mode_in,
  input  logic [AW-1:0]            base_addr_in,
  input  logic [CW-1:0]            count_in,
  input  logic [NUM_WORD_BITS-1:0] fill_value_in,
  input  logic                     s_valid_in,
  input  logic [NUM_WORD_BITS-1:0] s_data_in,
  output logic                     s_ready_out,
  output logic                     ram_write_enable_out,
  output logic [AW-1:0]            ram_address_out,
  output logic [NUM_WORD_BITS-1:0] ram_data_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [CW-1:0]            words_written_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  state_t                   r_state;
  logic [AW-1:0]            r_addr;
  logic [CW-1:0]            r_count;
  logic [NUM_WORD_BITS-1:0] r_fill;
  logic                     r_we;
  logic [AW-1:0]            r_ram_addr;
  logic [NUM_WORD_BITS-1:0] r_ram_data;
  logic                     r_busy;
  logic                     r_done;
  logic [CW-1:0]            r_words;

  state_t                   w_state_nxt;
  logic [AW-1:0]            w_addr_nxt;
  logic [CW-1:0]            w_count_nxt;
  logic [NUM_WORD_BITS-1:0] w_fill_nxt;
  logic                     w_we_nxt;
  logic [AW-1:0]            w_ram_addr_nxt;
  logic [NUM_WORD_BITS-1:0] w_ram_data_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic [CW-1:0]            w_words_nxt;
  logic                     w_write;
  logic [NUM_WORD_BITS-1:0] w_wdata;
  logic [CW-1:0]            w_words_inc;
  logic [AW-1:0]            w_addr_inc;

  assign w_words_inc = r_words + CW'(1);

  // Explicit wrap keeps non power-of-two depths inside the RAM.
  assign w_addr_inc = (r_addr == LAST_ADDR) ? '0
                                            : r_addr + AW'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_count_nxt    = r_count;
    w_fill_nxt     = r_fill;
    w_we_nxt       = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_data_nxt = r_ram_data;
    w_done_nxt     = 1'b0;
    w_words_nxt    = r_words;
    w_write        = 1'b0;
    w_wdata        = r_ram_data;

    unique case (r_state)
      IDLE: begin
        if (start_in) begin
          w_words_nxt = '0;
          if (count_in == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_addr_nxt  = base_addr_in;
            w_count_nxt = count_in;
            w_fill_nxt  = fill_value_in;
            w_state_nxt = mode_in ? FILL : STREAM;
          end
        end
      end
      STREAM: begin
        if (s_valid_in) begin
          w_write = 1'b1;
          w_wdata = s_data_in;
        end
      end
      FILL: begin
        w_write = 1'b1;
        w_wdata = r_fill;
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_write) begin
      w_we_nxt       = 1'b1;
      w_ram_addr_nxt = r_addr;
      w_ram_data_nxt = w_wdata;
      w_addr_nxt     = w_addr_inc;
      w_words_nxt    = w_words_inc;
      // Leaving STREAM on the last handshake drops ready next cycle.
      if (w_words_inc == r_count) begin
        w_state_nxt = DONE;
      end
    end
  end

  // Busy stays up through the done_out cycle, which is spent in IDLE.
  assign w_busy_nxt = (w_state_nxt != IDLE) ||
                      (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_fill     <= '0;
      r_we       <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      r_fill     <= w_fill_nxt;
      r_we       <= w_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_data <= w_ram_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_words    <= w_words_nxt;
    end
  end

  assign s_ready_out          = (r_state == STREAM);
  assign ram_write_enable_out = r_we;
  assign ram_address_out      = r_ram_addr;
  assign ram_data_out         = r_ram_data;
  assign busy_out             = r_busy;
  assign done_out             = r_done;
  assign words_written_out    = r_words;

endmodule

// File: tb/tb_ram_sequential_writer.sv
// tb_ram_sequential_writer: scoreboard bench for ram_sequential_writer.
// Expected writes are queued at stimulus time; a negedge monitor pops them.
module tb_ram_sequential_writer;

  localparam int DW = 32;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int CW = 11;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_in;
  logic          mode_in;
  logic [AW-1:0] base_addr_in;
  logic [CW-1:0] count_in;
  logic [DW-1:0] fill_value_in;
  logic          s_valid_in;
  logic [DW-1:0] s_data_in;
  logic          s_ready_out;
  logic          ram_write_enable_out;
  logic [AW-1:0] ram_address_out;
  logic [DW-1:0] ram_data_out;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] words_written_out;

  int total = 0;
  int bad   = 0;
  wr_t exp_q[$];
  logic [DW-1:0] mem [NW];
  logic mem_clr;
  int wcnt [NW];
  int wsnap [NW];

  always #5 clk = ~clk;

  ram_sequential_writer #(
    .NUM_WORD_BITS(DW),
    .NUM_WORDS(NW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start_in            (start_in),
    .mode_in             (mode_in),
    .base_addr_in        (base_addr_in),
    .count_in            (count_in),
    .fill_value_in       (fill_value_in),
    .s_valid_in          (s_valid_in),
    .s_data_in           (s_data_in),
    .s_ready_out         (s_ready_out),
    .ram_write_enable_out(ram_write_enable_out),
    .ram_address_out     (ram_address_out),
    .ram_data_out        (ram_data_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .words_written_out   (words_written_out)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // RAM model: commits at the edge where the strobe is sampled high.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'h5500_0000 + i;
    end else if (ram_write_enable_out) begin
      mem[ram_address_out] <= ram_data_out;
    end
  end

  always @(negedge clk) begin
    if (ram_write_enable_out) begin
      wr_t e;
      wcnt[ram_address_out]++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h want none",
                 ram_address_out, ram_data_out);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_address_out), 64'(e.a));
        chk("wr_data", 64'(ram_data_out), 64'(e.d));
      end
    end
  end

  task automatic do_start(input logic m, input logic [AW-1:0] b,
                          input logic [CW-1:0] c, input logic [DW-1:0] v);
    @(negedge clk);
    start_in = 1'b1;
    mode_in = m;
    base_addr_in = b;
    count_in = c;
    fill_value_in = v;
    if (m) begin
      for (int i = 0; i < int'(c); i++) exp_q.push_back('{a: AW'(b + i), d: v});
    end
    @(posedge clk);
    #1;
    start_in = 1'b0;
    mode_in = ~m;
    base_addr_in = 10'h3ab;
    count_in = 11'd1;
    fill_value_in = 32'hFFFF_FFFF;
    chk("busy_after_start", 64'(busy_out), 64'd1);
  endtask

  // Cycle index 0 is the cycle right after the start edge.
  task automatic wait_done(input int lim, input int poke,
                           output int ns, output int first,
                           output int last, output int dc);
    ns = 0; first = -1; last = -1; dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (i == poke) begin
        start_in = 1'b1; mode_in = 1'b0;
        base_addr_in = 10'd7; count_in = 11'd3;
      end else if (i == poke + 1) begin
        start_in = 1'b0;
      end
      if (ram_write_enable_out) begin
        ns++;
        if (first < 0) first = i;
        last = i;
      end
      if (done_out) begin
        dc = i;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic post_done();
    @(negedge clk);
    chk("done_one_cycle", 64'(done_out), 64'd0);
    chk("busy_idle", 64'(busy_out), 64'd0);
  endtask

  initial begin
    int ns, f, l, dc, errs;
    reset_n = 1'b0; mem_clr = 1'b1; start_in = 1'b0; mode_in = 1'b0;
    base_addr_in = '0; count_in = '0; fill_value_in = '0;
    s_valid_in = 1'b0; s_data_in = '0;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_we", 64'(ram_write_enable_out), 64'd0);
    chk("rst_addr", 64'(ram_address_out), 64'd0);
    chk("rst_data", 64'(ram_data_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_words", 64'(words_written_out), 64'd0);
    chk("rst_ready", 64'(s_ready_out), 64'd0);
    reset_n = 1'b1;

    // Fill 16 words at 0.
    do_start(1'b1, 10'd0, 11'd16, 32'hDEADBEEF);
    wait_done(40, -10, ns, f, l, dc);
    chk("fill_strobes", 64'(ns), 64'd16);
    chk("fill_first", 64'(f), 64'd1);
    chk("fill_consec", 64'(l - f + 1), 64'd16);
    chk("fill_done_cyc", 64'(dc), 64'(l + 1));
    chk("fill_words", 64'(words_written_out), 64'd16);
    post_done();
    chk("fill_words_hold", 64'(words_written_out), 64'd16);
    for (int i = 0; i < 16; i++) chk("fill_mem", 64'(mem[i]), 64'hDEADBEEF);
    chk("fill_mem16", 64'(mem[16]), 64'h5500_0010);

    // Stream 1..5 at 100, valid every other cycle.
    do_start(1'b0, 10'd100, 11'd5, 32'h0);
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk);
      chk("strm_ready", 64'(s_ready_out), 64'd1);
      s_valid_in = 1'b1;
      s_data_in = 32'(w);
      exp_q.push_back('{a: AW'(99 + w), d: 32'(w)});
      @(negedge clk);
      s_valid_in = 1'b0;
      s_data_in = 32'hBAD0_0000;
      chk("strm_strobe", 64'(ram_write_enable_out), 64'd1);
      if (w < 5) begin
        @(negedge clk);
        chk("strm_gap", 64'(ram_write_enable_out), 64'd0);
      end else begin
        chk("strm_ready_off", 64'(s_ready_out), 64'd0);
      end
    end
    @(negedge clk);
    chk("strm_done", 64'(done_out), 64'd1);
    chk("strm_words", 64'(words_written_out), 64'd5);
    post_done();
    for (int i = 0; i < 5; i++) chk("strm_mem", 64'(mem[100 + i]), 64'(i + 1));

    // Wrap-around fill.
    do_start(1'b1, 10'd1022, 11'd4, 32'hA5);
    wait_done(20, -10, ns, f, l, dc);
    chk("wrap_strobes", 64'(ns), 64'd4);
    chk("wrap_words", 64'(words_written_out), 64'd4);
    post_done();
    chk("wrap_mem0", 64'(mem[0]), 64'hA5);
    chk("wrap_mem1023", 64'(mem[1023]), 64'hA5);

    // Zero count, then a start pulse ignored mid-fill.
    do_start(1'b1, 10'd50, 11'd0, 32'h1);
    wait_done(10, -10, ns, f, l, dc);
    chk("zero_strobes", 64'(ns), 64'd0);
    chk("zero_done_cyc", 64'(dc), 64'd1);
    post_done();
    do_start(1'b1, 10'd500, 11'd10, 32'h0BAD_F00D);
    wait_done(30, 4, ns, f, l, dc);
    chk("ign_strobes", 64'(ns), 64'd10);
    chk("ign_done_cyc", 64'(dc), 64'd11);
    chk("ign_words", 64'(words_written_out), 64'd10);
    post_done();
    repeat (3) @(negedge clk);
    chk("ign_still_idle", 64'(busy_out), 64'd0);

    // Reset after 3 of 8 streamed words.
    do_start(1'b0, 10'd200, 11'd8, 32'h0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      s_valid_in = 1'b1;
      s_data_in = 32'h100 + w;
      exp_q.push_back('{a: AW'(200 + w), d: 32'h100 + w});
    end
    @(posedge clk);
    #1;
    s_valid_in = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_we", 64'(ram_write_enable_out), 64'd0);
    chk("mrst_addr", 64'(ram_address_out), 64'd0);
    chk("mrst_data", 64'(ram_data_out), 64'd0);
    chk("mrst_busy", 64'(busy_out), 64'd0);
    chk("mrst_words", 64'(words_written_out), 64'd0);
    chk("mrst_ready", 64'(s_ready_out), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) chk("mrst_mem", 64'(mem[200 + i]), 64'h100 + i);
    chk("mrst_mem203", 64'(mem[203]), 64'h5500_00CB);

    // Normal back-to-back stream after reset.
    do_start(1'b0, 10'd300, 11'd2, 32'h0);
    @(negedge clk);
    s_valid_in = 1'b1; s_data_in = 32'hCAFE_0001;
    exp_q.push_back('{a: 10'd300, d: 32'hCAFE_0001});
    @(negedge clk);
    s_data_in = 32'hCAFE_0002;
    exp_q.push_back('{a: 10'd301, d: 32'hCAFE_0002});
    @(negedge clk);
    s_valid_in = 1'b0;
    chk("b2b_strobe", 64'(ram_write_enable_out), 64'd1);
    @(negedge clk);
    chk("b2b_done", 64'(done_out), 64'd1);
    chk("b2b_words", 64'(words_written_out), 64'd2);
    post_done();

    // Full depth fill.
    for (int i = 0; i < NW; i++) wsnap[i] = wcnt[i];
    do_start(1'b1, 10'd0, 11'd1024, 32'hC0FF_EE11);
    wait_done(1100, -10, ns, f, l, dc);
    chk("full_strobes", 64'(ns), 64'd1024);
    chk("full_done_cyc", 64'(dc), 64'd1025);
    chk("full_words", 64'(words_written_out), 64'd1024);
    post_done();
    errs = 0;
    for (int i = 0; i < NW; i++) if (wcnt[i] - wsnap[i] != 1) errs++;
    chk("full_each_once", 64'(errs), 64'd0);
    chk("full_mem0", 64'(mem[0]), 64'hC0FF_EE11);
    chk("full_mem1023", 64'(mem[1023]), 64'hC0FF_EE11);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
